// File: rtl/alu_multicycle.sv
// Handshaked ALU with registered result; MUL (shift-add) and DIVU (restoring)
// iterate one bit per cycle for WIDTH cycles, all other ops complete in one.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpNot  = 4'h2;
    localparam logic [3:0] OpAnd  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpXor  = 4'h5;
    localparam logic [3:0] OpSlt  = 4'h6;
    localparam logic [3:0] OpEq   = 4'h7;
    localparam logic [3:0] OpMul  = 4'h8;
    localparam logic [3:0] OpDivu = 4'h9;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;

    logic [WIDTH-1:0]     b_opnd;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_carry;
    logic                 sc_ovf;

    logic [WIDTH:0]       mul_hi;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_d;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    // Single-cycle datapath, evaluated on the operands being accepted.
    always_comb begin
        b_opnd   = (in_op == OpSub) ? ~in_b : in_b;
        sum_w    = {1'b0, in_a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, (in_op == OpSub)};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (in_op)
            OpAdd, OpSub: begin
                sc_res   = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] == b_opnd[WIDTH-1]) &&
                           (sum_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpNot: sc_res = ~in_a;
            OpAnd: sc_res = in_a & in_b;
            OpOr:  sc_res = in_a | in_b;
            OpXor: sc_res = in_a ^ in_b;
            OpSlt: sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OpEq:  sc_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
            default: ;
        endcase
    end

    // One iteration step: acc holds {high, multiplier} for MUL, {remainder, quotient} for DIVU.
    always_comb begin
        mul_hi   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                            : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (op_q == OpMul) begin
            acc_d = {mul_hi, acc_q[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            out_res      <= '0;
            out_zero     <= 1'b0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q <= in_op;
                        a_q  <= in_a;
                        b_q  <= in_b;
                        if (in_op == OpMul || in_op == OpDivu) begin
                            state_q <= StBusy;
                            cnt_q   <= CW'(WIDTH);
                            acc_q   <= {{WIDTH{1'b0}}, (in_op == OpMul) ? in_b : in_a};
                        end else begin
                            state_q      <= StDone;
                            out_res      <= sc_res;
                            out_zero     <= (sc_res == '0);
                            out_carry    <= sc_carry;
                            out_overflow <= sc_ovf;
                        end
                    end
                end
                StBusy: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q      <= StDone;
                        out_res      <= acc_d[WIDTH-1:0];
                        out_zero     <= (acc_d[WIDTH-1:0] == '0);
                        out_carry    <= (op_q == OpMul) && (acc_d[2*WIDTH-1:WIDTH] != '0);
                        out_overflow <= (op_q == OpDivu) && (b_q == '0);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (WIDTH=8): directed literal cases plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_multicycle;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_carry;
    logic         out_overflow;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Returns {overflow, carry, zero, res} straight from the arithmetic definitions.
    function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0]  r;
        logic        c;
        logic        v;
        logic [15:0] p;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                r = a + b;
                c = (int'(a) + int'(b)) > 255;
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1: begin
                r = a - b;
                c = (a >= b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h2: r = ~a;
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            4'h7: r = (a == b) ? 8'h01 : 8'h00;
            4'h8: begin
                p = 16'(a) * 16'(b);
                r = p[7:0];
                c = (p[15:8] != 8'h00);
            end
            4'h9: begin
                if (b == 8'h00) begin
                    r = 8'hFF;
                    v = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            default: ;
        endcase
        return {v, c, (r == 8'h00), r};
    endfunction

    // Reference model: pending transaction, remaining busy cycles, expected outputs.
    initial begin
        bit          m_pend = 1'b0;
        bit          m_clr  = 1'b1;
        int          m_left = 0;
        logic [10:0] m_exp  = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", 32'(in_ready), 32'(!m_pend));
                chk("out_valid", 32'(out_valid), 32'(m_pend && m_left == 0));
                if (m_pend && m_left == 0) begin
                    m_clr = 1'b0;
                    chk("res", 32'(out_res), 32'(m_exp[7:0]));
                    chk("zero", 32'(out_zero), 32'(m_exp[8]));
                    chk("carry", 32'(out_carry), 32'(m_exp[9]));
                    chk("overflow", 32'(out_overflow), 32'(m_exp[10]));
                end else if (m_clr) begin
                    chk("reset_outputs", 32'({out_res, out_zero, out_carry, out_overflow}), 32'd0);
                end
            end
            if (rst) begin
                m_pend = 1'b0;
                m_clr  = 1'b1;
            end else if (!m_pend) begin
                if (in_valid) begin
                    m_pend = 1'b1;
                    m_exp  = model(in_op, in_a, in_b);
                    m_left = (in_op == 4'h8 || in_op == 4'h9) ? W : 0;
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (out_ready) begin
                m_pend = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    // Issue one op, check latency and literal result, hold it under back-pressure, release.
    task automatic run_lit(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] e_res, input logic e_z, input logic e_c,
                           input logic e_v, input int e_lat, input int hold);
        int lat;
        wait_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("lit_res", 32'(out_res), 32'(e_res));
        chk("lit_flags", 32'({out_zero, out_carry, out_overflow}), 32'({e_z, e_c, e_v}));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            in_op    = 4'h0;
            in_a     = 8'h01;
            in_b     = 8'h01;
            @(posedge clk); #1;
            chk("held_res", 32'(out_res), 32'(e_res));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_ack", 32'({in_ready, out_valid}), 32'b10);
    endtask

    function automatic logic [7:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", 32'({in_ready, out_valid, out_res, out_zero, out_carry, out_overflow}),
            32'({1'b1, 1'b0, 8'h00, 3'b000}));
        chk_en = 1'b1;

        run_lit(4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1, 5);
        run_lit(4'h1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1, 0);
        run_lit(4'h6, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1, 0);
        run_lit(4'h7, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1, 0);
        run_lit(4'h8, 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 9, 2);
        run_lit(4'h9, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 1'b0, 9, 0);
        run_lit(4'h9, 8'd5, 8'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 9, 0);
        run_lit(4'hC, 8'h33, 8'h44, 8'h00, 1'b1, 1'b0, 1'b0, 1, 0);

        // Reset during the 4th BUSY cycle of a MUL discards it.
        wait_idle();
        in_valid = 1'b1;
        in_op    = 4'h8;
        in_a     = 8'h0F;
        in_b     = 8'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_busy_reset",
            32'({in_ready, out_valid, out_res, out_zero, out_carry, out_overflow}),
            32'({1'b1, 1'b0, 8'h00, 3'b000}));
        run_lit(4'h0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0, 1'b0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = rnd_opnd();
            in_b      = rnd_opnd();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
